mem_port_arbiter: RTL and testbench

Sequences the single-ported unified instruction/data memory of the multicycle CPU and shares it between two requesters. Port 0 is the CPU memory interface, driven by the control FSM's fetch, load and store states. Port 1 is the loader/debug port used to preload or inspect memory. The block grants one requester at a time, registers the request, issues exactly one memory access, waits a fixed memory latency, then returns data with a one-cycle acknowledge.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-port arbiter and sequencer for the single-ported unified I/D memory.
//   Port 0 is the CPU memory interface and port 1 is the loader/debug port.
//   One requester is granted at a time. Its fields are latched directly into
//   the registered mem_* outputs and a single mem_cs strobe is issued. The
//   block then waits MEM_LAT cycles and returns a one-cycle ack together with
//   registered read data.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : ties go to the port that is not the last-grant pointer.
//     undefined : fixed priority, port 0 wins every tie.
//
// Ports
//   CLK, RSTn            clock, synchronous active-low reset
//   pN_req/we/be/addr/   request from port N (held until ack)
//     wdata
//   pN_ack, pN_rdata     one-cycle completion pulse, registered read data
//   mem_cs/we/be/addr/   registered memory strobe and fields (word address)
//     wdata
//   mem_rdata            memory read data, valid MEM_LAT cycles after mem_cs
//   busy, owner          not-idle flag, current or most recent grantee
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [3:0]    p0_be,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       win;

  // Byte offset bits are meaningless for a word-wide memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{p0_addr[1:0], p1_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req) win = ~last_grant;
    else                  win = p1_req;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not asking.
  assign win = ~p0_req;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            // The mem_* registers double as the latched request fields.
            state     <= ACCESS;
            busy      <= 1'b1;
            owner     <= win;
            mem_cs    <= 1'b1;
            mem_we    <= win ? p1_we : p0_we;
            mem_be    <= win ? p1_be : p0_be;
            mem_addr  <= win ? p1_addr[AW-1:2] : p0_addr[AW-1:2];
            mem_wdata <= win ? p1_wdata : p0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= win;
`endif
          end
        end
        ACCESS: begin
          mem_cs <= 1'b0;
          cnt    <= 4'(MEM_LAT);
          state  <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt==1 marks the cycle in which mem_rdata is valid.
          if (cnt == 4'd1) begin
            state <= RESP;
            if (owner) begin
              p1_ack <= 1'b1;
              if (!mem_we) p1_rdata <= mem_rdata;
            end else begin
              p0_ack <= 1'b1;
              if (!mem_we) p0_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a (MEM_LAT=1) with a byte-writable
// memory, instance b (MEM_LAT=4) with a read-only memory for latency, busy
// and mid-transaction reset checks.
module tb_mem_port_arbiter;
  localparam int LA = 1;
  localparam int LB = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int ptr      = 1;   // model of the last-grant pointer

  // ---------------- instance a ----------------
  logic        rst_a;
  logic        req0, we0, req1, we1;
  logic [3:0]  be0, be1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic        ack0, ack1, mcs, mwe, busy, owner;
  logic [31:0] rd0, rd1, mwd, mrd;
  logic [3:0]  mbe;
  logic [29:0] maddr;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LA)) dut_a (
    .CLK(CLK), .RSTn(rst_a),
    .p0_req(req0), .p0_we(we0), .p0_be(be0), .p0_addr(addr0), .p0_wdata(wd0),
    .p0_ack(ack0), .p0_rdata(rd0),
    .p1_req(req1), .p1_we(we1), .p1_be(be1), .p1_addr(addr1), .p1_wdata(wd1),
    .p1_ack(ack1), .p1_rdata(rd1),
    .mem_cs(mcs), .mem_we(mwe), .mem_be(mbe), .mem_addr(maddr), .mem_wdata(mwd),
    .mem_rdata(mrd), .busy(busy), .owner(owner));

  function automatic logic [31:0] fw(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h5A3C_96E1 ^ (i * 32'h0101_0103);
  endfunction

  // Memory a: one-cycle read latency; data outside the valid cycle is junk.
  logic [31:0] mem [0:63];
  logic [31:0] rdq;
  logic        rdv;
  always @(posedge CLK) begin
    rdv <= 1'b0;
    if (!rst_a) begin
      for (int i = 0; i < 64; i++) mem[i] <= fw(i);
    end else if (mcs) begin
      if (mwe) begin
        for (int b = 0; b < 4; b++)
          if (mbe[b]) mem[maddr[5:0]][8*b +: 8] <= mwd[8*b +: 8];
      end else begin
        rdq <= mem[maddr[5:0]];
        rdv <= 1'b1;
      end
    end
  end
  assign mrd = rdv ? rdq : 32'hBAD0_BAD0;

  // ---------------- instance b ----------------
  logic        rst_b;
  logic        breq, back, bbusy, bowner, bcs, bwe, back1;
  logic [31:0] baddr, brd, brd1, bwd, bmrd;
  logic [3:0]  bbe;
  logic [29:0] bmaddr;
  logic        zero1 = 1'b0;
  logic [3:0]  zero4 = 4'h0;
  logic [31:0] zero32 = 32'h0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LB)) dut_b (
    .CLK(CLK), .RSTn(rst_b),
    .p0_req(breq), .p0_we(zero1), .p0_be(4'hF), .p0_addr(baddr), .p0_wdata(zero32),
    .p0_ack(back), .p0_rdata(brd),
    .p1_req(zero1), .p1_we(zero1), .p1_be(zero4), .p1_addr(zero32), .p1_wdata(zero32),
    .p1_ack(back1), .p1_rdata(brd1),
    .mem_cs(bcs), .mem_we(bwe), .mem_be(bbe), .mem_addr(bmaddr), .mem_wdata(bwd),
    .mem_rdata(bmrd), .busy(bbusy), .owner(bowner));

  logic [3:0]  bv;
  logic [31:0] bq;
  always @(posedge CLK) begin
    bv <= {bv[2:0], bcs & ~bwe};
    if (bcs) bq <= fw(int'(bmaddr[5:0]));
  end
  assign bmrd = bv[LB-1] ? bq : 32'hBAD0_BAD0;

  // ---------------- model and helpers ----------------
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rd0 = 32'h0, exp_rd1 = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (ptr == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  // Apply the model effect of a completed grant and check read data.
  task automatic retire(input int w, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[7:2]);
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end else if (w == 0) exp_rd0 = ref_mem[idx];
    else                 exp_rd1 = ref_mem[idx];
    chk("rdata0", rd0, exp_rd0);
    chk("rdata1", rd1, exp_rd1);
    ptr = w;
  endtask

  // One transaction from IDLE, either or both ports requesting.
  task automatic run(input bit r0, input bit r1,
                     input logic w0, input logic w1, input logic [3:0] b0, input logic [3:0] b1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1);
    int w, n;
    bit got;
    w = pick(r0, r1);
    req0 = r0; we0 = w0; be0 = b0; addr0 = a0; wd0 = d0;
    req1 = r1; we1 = w1; be1 = b1; addr1 = a1; wd1 = d1;
    n = 0; got = 0;
    while (!got && n < 40) begin
      tick; n++;
      if (ack0 || ack1) got = 1;
    end
    req0 = 0; req1 = 0;
    chk("ack_seen", 64'(got), 64'd1);
    chk("winner", 64'(ack1), 64'(w));
    chk("single_ack", 64'(ack0 & ack1), 64'd0);
    chk("latency", 64'(n), 64'(2 + LA));
    if (w == 0) retire(0, w0, b0, a0, d0);
    else        retire(1, w1, b1, a1, d1);
    tick;
    chk("idle_after", 64'({busy, ack0, ack1}), 64'd0);
  endtask

  initial begin
    int n, w, last;
    bit got;
    logic [31:0] t;
    rst_a = 0; rst_b = 0;
    req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wd0 = 0;
    req1 = 0; we1 = 0; be1 = 0; addr1 = 0; wd1 = 0;
    breq = 0; baddr = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = fw(i);
    repeat (3) tick;
    chk("rst_acks", 64'({ack0, ack1}), 64'd0);
    chk("rst_mem", {mcs, mwe, mbe, maddr, mwd}, 64'd0);
    chk("rst_rd", {rd0, rd1}, 64'd0);
    chk("rst_busy_owner", 64'({busy, owner}), 64'd0);
    rst_a = 1; rst_b = 1;
    tick;

    // p0 read of 0x10
    req0 = 1; we0 = 0; be0 = 4'hF; addr0 = 32'h10;
    tick;
    chk("d1_cs", 64'({mcs, mwe, busy}), 64'b101);
    chk("d1_addr", 64'(maddr), 64'h4);
    tick;
    chk("d1_c2", 64'({mcs, ack0}), 64'd0);
    tick;
    chk("d1_ack", 64'({ack0, ack1}), 64'b10);
    chk("d1_rd", 64'(rd0), 64'hDEADBEEF);
    exp_rd0 = 32'hDEADBEEF;
    req0 = 0;
    tick;
    chk("d1_idle", 64'({busy, ack0}), 64'd0);

    // p1 partial write to 0x20
    req1 = 1; we1 = 1; be1 = 4'b0011; addr1 = 32'h20; wd1 = 32'hA5A5_A5A5;
    tick;
    chk("d2_cs", 64'({mcs, mwe, mbe, owner}), 64'b11_0011_1);
    chk("d2_addr", {maddr, mwd}, {34'h8, 32'hA5A5_A5A5});
    tick; tick;
    chk("d2_ack", 64'({ack0, ack1}), 64'b01);
    chk("d2_rd1", 64'(rd1), 64'h0);
    req1 = 0;
    for (int b = 0; b < 2; b++) ref_mem[8][8*b +: 8] = 8'hA5;
    tick;
    run(1, 0, 0, 0, 4'hF, 0, 32'h20, 0, 0, 0);
    t = fw(8);
    chk("d2_readback", 64'(rd0), 64'({t[31:16], 16'hA5A5}));

    // both ports requesting continuously: four grants
    req0 = 1; we0 = 0; be0 = 4'hF; addr0 = 32'h40;
    req1 = 1; we1 = 0; be1 = 4'hF; addr1 = 32'h44;
    for (int k = 0; k < 4; k++) begin
      w = pick(1, 1);
      n = 0; got = 0;
      while (!got && n < 40) begin
        tick; n++;
        if (ack0 || ack1) got = 1;
      end
      if (k == 3) begin req0 = 0; req1 = 0; end
      chk("cont_seen", 64'(got), 64'd1);
      chk("cont_order", 64'(ack1), 64'(w));
      chk("cont_gap", 64'(n), 64'(k == 0 ? 2 + LA : 3 + LA));
      retire(w, 0, 4'hF, w ? 32'h44 : 32'h40, 0);
    end
    tick;

    // p0 drops req mid-transaction: ack still comes
    req0 = 1; we0 = 0; addr0 = 32'h10;
    tick; tick;
    req0 = 0;
    tick;
    chk("drop_ack", 64'(ack0), 64'd1);
    retire(0, 0, 4'hF, 32'h10, 0);
    tick;
    chk("drop_idle", 64'({busy, ack0}), 64'd0);

    // randomized traffic against the model
    for (int r = 0; r < 30; r++) begin
      int pat;
      pat = $urandom_range(1, 3);
      run(pat[0], pat[1], 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
          32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), $urandom, $urandom);
    end

    // MEM_LAT=4 instance: latency, busy window, next grant spacing
    breq = 1; baddr = 32'h30;
    got = 0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      chk("b_busy", 64'(bbusy), 64'd1);
      chk("b_ack", 64'(back), 64'(c == 6));
    end
    chk("b_rd", 64'(brd), 64'(fw(12)));
    tick;   // cycle 7: IDLE, req still high -> new transaction
    chk("b_c7", 64'({bbusy, bcs}), 64'd0);
    tick;   // cycle 8
    chk("b_c8_cs", 64'(bcs), 64'd1);
    breq = 0;
    tick; tick;   // cycle 10: inside WAIT
    rst_b = 0;
    tick;
    chk("b_rst", 64'({bbusy, back, bcs, bowner}), 64'd0);
    chk("b_rst_rd", 64'(brd), 64'd0);
    rst_b = 1;
    last = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (back) last = 1;
    end
    chk("b_no_ack", 64'(last), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
